// File: rtl/cordic_pkg.sv
// Shared constants, frame sizing and serializer state encoding for the CORDIC result path.
package cordic_pkg;

  localparam int CORDIC_WIDTH   = 16;
  localparam int CORDIC_PHASE_W = 32;

  typedef enum logic {
    EMPTY  = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

  function automatic int nbytes(input int mag_w, input int phase_w);
    return mag_w / 8 + phase_w / 8;
  endfunction

endpackage

// File: rtl/cordic_result_fifo.sv
// DEPTH-entry result buffer; one-cycle write-to-head visibility.
// Push is refused while full even if a pop lands on the same edge.
module cordic_result_fifo #(
  parameter int DW    = 48,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_dat,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_one,
  output logic [DW-1:0] o_head_dat
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] r_count;
  logic [DW-1:0] r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_one   = (r_count == CW'(1));
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      r_count <= r_count - CW'(1);
    end
  end

  if (DEPTH == 1) begin : g_single
    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[0] <= i_push_dat;
      end
    end
    assign o_head_dat = r_mem[0];
  end else begin : g_ring
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
      end
    end
    assign o_head_dat = r_mem[r_rd_ptr];
  end

endmodule

// File: rtl/cordic_out_serializer.sv
// Buffers {mag, phase} results and streams them LSB-byte first; first byte the cycle after accept.
// Bytes hold steady under out_ready stall; res_ready depends only on buffer occupancy.
module cordic_out_serializer
  import cordic_pkg::*;
#(
  parameter int WIDTH   = CORDIC_WIDTH,
  parameter int PHASE_W = CORDIC_PHASE_W,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               res_valid,
  output logic               res_ready,
  input  logic [WIDTH-1:0]   res_mag,
  input  logic [PHASE_W-1:0] res_phase,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic               frame_last,
  output logic               busy
);

  localparam int NB = nbytes(WIDTH, PHASE_W);
  localparam int IW = $clog2(NB);
  localparam int DW = WIDTH + PHASE_W;

  logic [1:0]    r_rst_sync;
  logic          w_rst;
  logic          w_full;
  logic          w_empty;
  logic          w_one;
  logic          w_push;
  logic          w_pop;
  logic          w_out_hs;
  logic          w_last;
  logic [DW-1:0] w_head;
  logic [7:0]    w_bytes [2**IW];
  ser_state_t    r_state;
  logic [IW-1:0] r_idx;

  // Assert immediately, release two edges after rst drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rst_sync <= 2'b11;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
  end
  assign w_rst = r_rst_sync[1];

  cordic_result_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (w_rst),
    .i_push     (w_push),
    .i_push_dat ({res_phase, res_mag}),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_one      (w_one),
    .o_head_dat (w_head)
  );

  assign res_ready  = !w_full;
  assign busy       = !w_empty;
  assign out_valid  = (r_state == STREAM);
  assign w_last     = (r_idx == IW'(NB - 1));
  assign frame_last = out_valid && w_last;
  assign w_out_hs   = out_valid && out_ready;
  assign w_push     = res_valid && !w_full;
  assign w_pop      = w_out_hs && w_last;

  // Head entry is {phase, mag}, so byte k is simply bits [8k+7:8k].
  for (genvar k = 0; k < 2**IW; k++) begin : g_bytes
    if (k < NB) begin : g_dat
      assign w_bytes[k] = w_head[8*k +: 8];
    end else begin : g_pad
      assign w_bytes[k] = 8'h00;
    end
  end
  assign out_byte = out_valid ? w_bytes[r_idx] : 8'h00;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_state <= EMPTY;
      r_idx   <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            r_state <= STREAM;
          end
        end
        STREAM: begin
          if (w_out_hs) begin
            if (w_last) begin
              r_idx <= '0;
              if (w_one && !w_push) begin
                r_state <= EMPTY;
              end
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/cordic_out_serializer.md
# cordic_out_serializer

Result-side stage that follows the CORDIC vectoring core inside the TT wrapper. It accepts one {magnitude, phase} result per handshake and buffers up to DEPTH results. It streams each result to the 8-bit output pins as a byte frame, least-significant byte first: magnitude bytes, then phase bytes. It decouples the core from a slow pin-side consumer so that the core can hand over its next result while the current frame is still draining.

## Interface
- WIDTH, 16, magnitude width in bits; must be a multiple of 8.
- PHASE_W, 32, phase width in bits; must be a multiple of 8.
- DEPTH, 2, number of buffered results; legal values are 1, 2 and 4.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- res_valid  input  1  the core presents a result.
- res_ready  output  1  the buffer can accept a result (= not full).
- res_mag  input  WIDTH  magnitude; sampled on the res handshake.
- res_phase  input  PHASE_W  phase; sampled on the res handshake.
- out_valid  output  1  out_byte holds a valid byte.
- out_ready  input  1  the consumer takes the byte.
- out_byte  output  8  current byte of the head frame.
- frame_last  output  1  high when out_byte is the final byte of its frame.
- busy  output  1  at least one result is buffered.

## Operation
- NBYTES = WIDTH/8 + PHASE_W/8 (6 at the defaults).
- Byte k of a frame:
  - k < WIDTH/8: res_mag[8k+7:8k].
  - otherwise: res_phase bits, starting at k − WIDTH/8, LSB first.
- A transfer occurs on a rising edge where valid && ready. This rule applies to both ports.
- Input side:
  - res_ready = (count != DEPTH). It depends on count only and never on out_ready.
  - When full, a result is not accepted, even if the last byte pops in the same cycle.
  - An accepted result is written at the tail; count increments.
- Output side, two-state FSM:
  - EMPTY: count == 0. out_valid = 0.
  - STREAM: count > 0. out_valid = 1 and out_byte = byte[idx] of the head entry.
  - In STREAM, an out handshake with idx < NBYTES−1 increments idx.
  - A handshake with idx == NBYTES−1 resets idx to 0, pops the head and decrements count.
  - After that pop, the FSM moves to EMPTY if count becomes 0; otherwise it stays in STREAM with no bubble cycle.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. For DEPTH = 1 the pointers are absent.
- frame_last = out_valid && (idx == NBYTES−1).
- busy = (count != 0).
- Stability rule: while out_valid && !out_ready, out_byte and frame_last must not change.
- Inputs are not checked for X. res_mag and res_phase are ignored when no res handshake occurs.

## Timing
- Reset (async assert, sync release inside the design):
  - count = 0, idx = 0, pointers = 0, FSM = EMPTY.
  - Outputs: out_valid = 0, out_byte = 0x00, frame_last = 0, busy = 0, res_ready = 1.
- Latency: a result accepted at edge N into an empty buffer gives out_valid = 1 and byte 0 in the cycle after N.
- With out_ready held high, a frame takes NBYTES cycles. Consecutive buffered frames stream with no gap.
- out_valid, out_byte, frame_last and busy are driven from registers or from a register-only mux, with no input-to-output combinational path.
- res_ready comes from the count register only.
- Reset asserted mid-frame: all buffered frames are discarded. The output deasserts asynchronously; after release, the next frame starts at byte 0.

## Structure
- Shared package cordic_pkg holds:
  - CORDIC_WIDTH = 16 and CORDIC_PHASE_W = 32.
  - The NBYTES computation as a localparam or constant function.
  - FSM state encoding: EMPTY, STREAM.
- Sub-module cordic_result_fifo:
  - DEPTH-entry storage of {phase, mag}, with tail/head pointers and count.
  - Interface: push, pop, full, empty, head data.
- The top level holds the FSM, the idx counter and the byte-select mux.

## Test plan
- Single frame: push mag = 0x1234, phase = 0xDEADBEEF, with out_ready held at 1. Required: out_byte sequence 34 12 EF BE AD DE on consecutive cycles, with frame_last only on DE. After DE, out_valid = 0 and busy = 0.
- Backpressure: same frame, with out_ready toggling 1-0-0-1 per cycle. Required: out_byte is held while it is stalled; the sequence is unchanged, with no loss or duplication.
- Back-to-back: push 0x0001/0x00000002 and then 0xFFFF/0x80000000 on consecutive cycles. Required: res_ready drops to 0 after the second push (DEPTH = 2). Output is 01 00 02 00 00 00 FF FF 00 00 00 80, with no bubble between frames.
- Full plus pop: while full and the last byte is being popped, assert res_valid. Required: the result is not accepted that cycle; res_ready = 1 on the next cycle and the push then succeeds.
- Reset mid-frame: assert rst after byte 2 of a frame. Required: out_valid = 0, busy = 0 and res_ready = 1 immediately. After release, a new push of 0xAAAA/0x55555555 streams AA AA 55 55 55 55 from byte 0.
